fw_interface_regs: RTL and testbench
====================================

# fw_interface_regs

Wishbone classic slave that firmware on the SoC CPU writes to in order to report test progress to the simulation bench. It holds the report/warning/error/expected/measured words and assembles a NUL-terminated ASCII string one byte per write. On command it issues one-shot strobes, which the downstream firmware-interface test logic edge-detects, prints and compares. It is synthesizable, so that the same firmware image runs unchanged in simulation.

## Interface
- PULSE_CYCLES, 4: cycles each new_* strobe is held high (legal range 2..15).
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-low (0 = reset).
- wb_adr_i  in  5  byte address; [4:2] selects the register, [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables; honoured per byte on all RW registers.
- wb_we_i  in  1  write enable.
- wb_cyc_i, wb_stb_i  in  1 each  bus cycle / strobe.
- wb_dat_o  out  32  read data; valid while wb_ack_o is high.
- wb_ack_o  out  1  single-cycle acknowledge.
- new_report, new_warning, new_error, new_compare  out  1 each  event strobes.
- report_reg, warning_reg, error_reg, expected_reg, measured_reg  out  32 each  register contents.
- index  out  6  string byte address.
- data  out  8  string byte.
- write_mem  out  1  one-cycle string byte write strobe.

## Operation
- Register map (offset: name, access):
  - 0x00 CTRL, W: bits [3:0] = report/warning/error/compare triggers.
  - 0x04 REPORT, 0x08 WARNING, 0x0C ERROR, 0x10 EXPECTED, 0x14 MEASURED: RW.
  - 0x18 STRING, W: byte in [7:0], requires wb_sel_i[0].
  - 0x1C STATUS: R = {26'b0, dropped, overflow, busy, 3'b0} in bits [5:0]? No: R = {24'b0, wr_ptr[5:0], overflow, dropped, busy} is too wide; defined layout is [0] busy, [1] dropped, [2] overflow, [8:3] wr_ptr, rest 0. W1C on bits [2:1].
- Reads of CTRL and STRING return 0. Writes to STATUS bits other than [2:1] are ignored.
- STRING write with byte b at wr_ptr p:
  - b != 0 and p < 63: data = b, index = p, write_mem pulses; then p increments.
  - b != 0 and p == 63: the byte is not written, overflow is set, and p is unchanged. Location 63 is reserved for the terminator.
  - b == 0: writes 0x00 at p, then p resets to 0.
- CTRL write with any trigger bit set:
  - Accepted only in IDLE. The set bits are latched and the FSM enters PULSE.
  - In PULSE or GAP the write is ignored and dropped is set.
  - A write with all bits clear has no effect.
- Pulse FSM:
  - IDLE: all strobes low; busy = 0.
  - PULSE: the latched strobes are high for exactly PULSE_CYCLES cycles (counter loads PULSE_CYCLES-1 and counts down to 0), then the FSM goes to GAP.
  - GAP: all strobes low for one cycle, then the FSM returns to IDLE. The gap guarantees that the next trigger produces a rising edge.
- Multiple trigger bits in one write assert their strobes simultaneously.
- The string pointer does not auto-clear on a trigger; firmware terminates the string with a 0x00 write before triggering.

## Timing
- Ack:
  - wb_ack_o rises in the cycle after wb_cyc_i & wb_stb_i are sampled high with ack low, and stays high for one cycle. Back-to-back accesses therefore take at least 2 cycles each.
  - Register update, write_mem, and FSM entry to PULSE all occur on the same edge that raises wb_ack_o.
- Strobe latency: a CTRL write acked at edge N drives new_* high from N through N+PULSE_CYCLES-1, low at N+PULSE_CYCLES (GAP), and IDLE at N+PULSE_CYCLES+1.
- busy = 1 from edge N until IDLE is re-entered.
- write_mem is high for exactly the one cycle following the accepting edge; index and data hold their values until the next string write.
- Reset (wb_rst_i == 0 at an edge):
  - wb_ack_o, write_mem and all strobes = 0.
  - All 32-bit registers = 0.
  - index, data, wr_ptr = 0; dropped and overflow = 0; FSM = IDLE.
  - wb_dat_o = 0.
- Reset asserted mid-PULSE drops the strobes on that same edge. A bus cycle in progress is not acked.
- wb_cyc_i deasserted before the ack: no write side effects occur.

## Test plan
- Reset, then read all offsets: REPORT through MEASURED read 0; STATUS reads 0; every access acks in 1 cycle.
- Write 0xDEADBEEF to EXPECTED with wb_sel_i = 4'b0011, then read: 0x0000BEEF; expected_reg == 0x0000BEEF.
- Write STRING bytes 'P','A','S','S',0x00: write_mem pulses 5 times with index 0..4 and data 0x50,0x41,0x53,0x53,0x00; the STATUS wr_ptr field reads 0 afterwards.
- Write 64 nonzero bytes: index 0..62 are written; the 64th byte gives no write_mem pulse; STATUS reads overflow = 1, wr_ptr = 63. Write 0x4 to STATUS clears overflow.
- PULSE_CYCLES = 4, write CTRL = 0x9: new_report and new_compare are high for 4 cycles and low for 1 cycle, then busy = 0. A CTRL = 0x2 write during PULSE produces no new_warning and sets dropped = 1.
- Drive wb_rst_i = 0 on the 2nd strobe cycle: strobes fall on that edge; after release STATUS = 0 and a new CTRL = 0x1 gives a full 4-cycle new_report.

Source files
------------

// File: rtl/fw_interface_regs.sv
// fw_interface_regs: Wishbone classic slave through which SoC firmware
// reports test progress to the simulation bench. It holds report/warning/
// error/expected/measured words, assembles a NUL-terminated string one
// byte per write, and issues fixed-length one-shot event strobes.
//
// Bus handshake: an access is accepted on the rising edge where
// wb_cyc_i & wb_stb_i are high and wb_ack_o is low. That same edge raises
// wb_ack_o for exactly one cycle, applies any write side effects, and
// registers read data so wb_dat_o is valid while wb_ack_o is high.
module fw_interface_regs #(
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        new_report,
  output logic        new_warning,
  output logic        new_error,
  output logic        new_compare,
  output logic [31:0] report_reg,
  output logic [31:0] warning_reg,
  output logic [31:0] error_reg,
  output logic [31:0] expected_reg,
  output logic [31:0] measured_reg,
  output logic [5:0]  index,
  output logic [7:0]  data,
  output logic        write_mem,
  output logic [1:0]  fsm_state_o
);

  // Register indices taken from wb_adr_i[4:2].
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_REPORT   = 3'd1;
  localparam logic [2:0] REG_WARNING  = 3'd2;
  localparam logic [2:0] REG_ERROR    = 3'd3;
  localparam logic [2:0] REG_EXPECTED = 3'd4;
  localparam logic [2:0] REG_MEASURED = 3'd5;
  localparam logic [2:0] REG_STRING   = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  // Last string location is reserved for the terminator.
  localparam logic [5:0] PTR_LAST = 6'd63;
  localparam logic [3:0] CNT_LOAD = 4'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Registered state
  logic        ack_q,      ack_d;
  logic [31:0] rdata_q,    rdata_d;
  logic [31:0] report_q,   report_d;
  logic [31:0] warning_q,  warning_d;
  logic [31:0] error_q,    error_d;
  logic [31:0] expected_q, expected_d;
  logic [31:0] measured_q, measured_d;
  logic [5:0]  wr_ptr_q,   wr_ptr_d;
  logic [5:0]  index_q,    index_d;
  logic [7:0]  data_q,     data_d;
  logic        wmem_q,     wmem_d;
  logic        dropped_q,  dropped_d;
  logic        overflow_q, overflow_d;
  state_t      state_q,    state_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [3:0]  trig_q,     trig_d;

  // Decoded access qualifiers
  logic       acc;
  logic       wr_acc;
  logic       rd_acc;
  logic [2:0] reg_idx;
  logic       ctrl_trig;
  logic       busy;
  logic       unused_adr;

  assign acc       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_acc    = acc & wb_we_i;
  assign rd_acc    = acc & ~wb_we_i;
  assign reg_idx   = wb_adr_i[4:2];
  assign ctrl_trig = wr_acc && (reg_idx == REG_CTRL) && (wb_dat_i[3:0] != 4'b0);
  assign busy      = (state_q != ST_IDLE);
  // Byte-lane address bits carry no meaning for word registers.
  assign unused_adr = ^wb_adr_i[1:0];

  // Merge write data into a register honouring the byte enables.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Bus decode: ack generation, read mux, register writes, string and status.
  always_comb begin
    ack_d      = acc;
    rdata_d    = 32'b0;
    report_d   = report_q;
    warning_d  = warning_q;
    error_d    = error_q;
    expected_d = expected_q;
    measured_d = measured_q;
    wr_ptr_d   = wr_ptr_q;
    index_d    = index_q;
    data_d     = data_q;
    wmem_d     = 1'b0;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;

    if (rd_acc) begin
      case (reg_idx)
        REG_REPORT:   rdata_d = report_q;
        REG_WARNING:  rdata_d = warning_q;
        REG_ERROR:    rdata_d = error_q;
        REG_EXPECTED: rdata_d = expected_q;
        REG_MEASURED: rdata_d = measured_q;
        REG_STATUS:   rdata_d = {23'b0, wr_ptr_q, overflow_q, dropped_q, busy};
        default:      rdata_d = 32'b0;
      endcase
    end

    if (wr_acc) begin
      case (reg_idx)
        REG_REPORT:   report_d   = byte_merge(report_q,   wb_dat_i, wb_sel_i);
        REG_WARNING:  warning_d  = byte_merge(warning_q,  wb_dat_i, wb_sel_i);
        REG_ERROR:    error_d    = byte_merge(error_q,    wb_dat_i, wb_sel_i);
        REG_EXPECTED: expected_d = byte_merge(expected_q, wb_dat_i, wb_sel_i);
        REG_MEASURED: measured_d = byte_merge(measured_q, wb_dat_i, wb_sel_i);
        REG_STRING: begin
          if (wb_sel_i[0]) begin
            if (wb_dat_i[7:0] == 8'h00) begin
              // Terminator: always written, then the string restarts at 0.
              wmem_d   = 1'b1;
              index_d  = wr_ptr_q;
              data_d   = 8'h00;
              wr_ptr_d = 6'd0;
            end else if (wr_ptr_q != PTR_LAST) begin
              wmem_d   = 1'b1;
              index_d  = wr_ptr_q;
              data_d   = wb_dat_i[7:0];
              wr_ptr_d = wr_ptr_q + 6'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        REG_STATUS: begin
          if (wb_sel_i[0]) begin
            if (wb_dat_i[1]) dropped_d  = 1'b0;
            if (wb_dat_i[2]) overflow_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A trigger arriving while a pulse sequence is running is lost.
    if (ctrl_trig && busy) dropped_d = 1'b1;
  end

  // Bus-side register state.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q      <= 1'b0;
      rdata_q    <= 32'b0;
      report_q   <= 32'b0;
      warning_q  <= 32'b0;
      error_q    <= 32'b0;
      expected_q <= 32'b0;
      measured_q <= 32'b0;
      wr_ptr_q   <= 6'd0;
      index_q    <= 6'd0;
      data_q     <= 8'd0;
      wmem_q     <= 1'b0;
      dropped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      report_q   <= report_d;
      warning_q  <= warning_d;
      error_q    <= error_d;
      expected_q <= expected_d;
      measured_q <= measured_d;
      wr_ptr_q   <= wr_ptr_d;
      index_q    <= index_d;
      data_q     <= data_d;
      wmem_q     <= wmem_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  // Pulse FSM next state: latch triggers in IDLE, hold for PULSE_CYCLES, one-cycle gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trig_d      = trig_q;
    new_report  = 1'b0;
    new_warning = 1'b0;
    new_error   = 1'b0;
    new_compare = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_trig) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_LOAD;
          trig_d  = wb_dat_i[3:0];
        end
      end
      ST_PULSE: begin
        new_report  = trig_q[0];
        new_warning = trig_q[1];
        new_error   = trig_q[2];
        new_compare = trig_q[3];
        if (cnt_q == 4'd0) begin
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        // Strobes low for one cycle so the next trigger is a clean edge.
        state_d = ST_IDLE;
        trig_d  = 4'b0;
      end
      default: begin
        state_d = ST_IDLE;
        trig_d  = 4'b0;
      end
    endcase
  end

  // Pulse FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      trig_q  <= 4'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = rdata_q;
  assign report_reg   = report_q;
  assign warning_reg  = warning_q;
  assign error_reg    = error_q;
  assign expected_reg = expected_q;
  assign measured_reg = measured_q;
  assign index        = index_q;
  assign data         = data_q;
  assign write_mem    = wmem_q;
  assign fsm_state_o  = state_q;

endmodule

// File: tb/tb_fw_interface_regs.sv
// Bench for fw_interface_regs: bus access tasks, a string-write scoreboard
// fed when STRING writes are driven and drained on write_mem, read-data
// expectations queued per read, and directed pulse/reset sequences.
module tb_fw_interface_regs;

  localparam logic [4:0] A_CTRL     = 5'h00;
  localparam logic [4:0] A_REPORT   = 5'h04;
  localparam logic [4:0] A_WARNING  = 5'h08;
  localparam logic [4:0] A_ERROR    = 5'h0C;
  localparam logic [4:0] A_EXPECTED = 5'h10;
  localparam logic [4:0] A_MEASURED = 5'h14;
  localparam logic [4:0] A_STRING   = 5'h18;
  localparam logic [4:0] A_STATUS   = 5'h1C;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic [4:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        new_report, new_warning, new_error, new_compare;
  logic [31:0] report_reg, warning_reg, error_reg, expected_reg, measured_reg;
  logic [5:0]  index;
  logic [7:0]  data;
  logic        write_mem;
  logic [1:0]  fsm_state_o;

  logic [3:0]  strobes;
  assign strobes = {new_compare, new_error, new_warning, new_report};

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] str_exp_q[$];
  logic [31:0] rd_exp_q[$];

  logic [3:0] strb_log[8];
  logic       busy_log[8];

  fw_interface_regs #(.PULSE_CYCLES(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .new_report(new_report), .new_warning(new_warning),
    .new_error(new_error), .new_compare(new_compare), .report_reg(report_reg),
    .warning_reg(warning_reg), .error_reg(error_reg),
    .expected_reg(expected_reg), .measured_reg(measured_reg),
    .index(index), .data(data), .write_mem(write_mem),
    .fsm_state_o(fsm_state_o)
  );

  // Clock
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wm_word(input int idx, input logic [7:0] b);
    logic [5:0] i6;
    i6 = idx[5:0];
    return {18'b0, i6, b};
  endfunction

  // One Wishbone classic access; reads compare wb_dat_o against a queued expectation.
  task automatic bus_cycle(input string tag, input logic we, input logic [4:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic [31:0] exp_rd);
    int   lat;
    logic got;
    @(negedge wb_clk_i);
    if (wb_ack_o) @(negedge wb_clk_i);
    if (!we) rd_exp_q.push_back(exp_rd);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    got = 1'b0; lat = 0;
    while (!got && lat < 4) begin
      @(posedge wb_clk_i); #1;
      lat++;
      if (wb_ack_o) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_ack_timeout"}, 32'd0, 32'd1);
      if (!we) void'(rd_exp_q.pop_front());
    end else begin
      check({tag, "_ack_lat"}, 32'(lat), 32'd1);
      if (!we) check(tag, wb_dat_o, rd_exp_q.pop_front());
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus_cycle("wr", 1'b1, adr, dat, sel, 32'b0);
  endtask

  task automatic rd(input string tag, input logic [4:0] adr, input logic [31:0] exp);
    bus_cycle(tag, 1'b0, adr, 32'b0, 4'hF, exp);
  endtask

  // Push the expected string-memory write, then drive the STRING write.
  task automatic str_wr(input logic [7:0] b, input int exp_idx, input logic expect_wm);
    if (expect_wm) str_exp_q.push_back(wm_word(exp_idx, b));
    wr(A_STRING, {24'b0, b}, 4'hF);
  endtask

  // Scoreboard drain: every write_mem cycle must match the oldest expectation.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (write_mem) begin
        if (str_exp_q.size() == 0)
          check("write_mem_unexpected", {18'b0, index, data}, 32'hFFFF_FFFF);
        else
          check("write_mem", {18'b0, index, data}, str_exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset
    wb_rst_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_wmem", {31'b0, write_mem}, 32'd0);
    check("rst_strobes", {28'b0, strobes}, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    check("rst_idx_data", {18'b0, index, data}, 32'd0);
    check("rst_report", report_reg, 32'd0);
    check("rst_measured", measured_reg, 32'd0);
    wb_rst_i = 1'b1;

    // Reads after reset
    rd("rd_report0", A_REPORT, 32'd0);
    rd("rd_warning0", A_WARNING, 32'd0);
    rd("rd_error0", A_ERROR, 32'd0);
    rd("rd_expected0", A_EXPECTED, 32'd0);
    rd("rd_measured0", A_MEASURED, 32'd0);
    rd("rd_status0", A_STATUS, 32'd0);
    rd("rd_ctrl0", A_CTRL, 32'd0);
    rd("rd_string0", A_STRING, 32'd0);

    // RW registers, full and partial byte enables
    begin
      logic [31:0] v[5];
      for (int i = 0; i < 5; i++) v[i] = $urandom();
      wr(A_REPORT, v[0], 4'hF);
      wr(A_WARNING, v[1], 4'hF);
      wr(A_ERROR, v[2], 4'hF);
      wr(A_MEASURED, v[4], 4'hF);
      rd("rd_report", A_REPORT, v[0]);
      rd("rd_warning", A_WARNING, v[1]);
      rd("rd_error", A_ERROR, v[2]);
      rd("rd_measured", A_MEASURED, v[4]);
      check("report_reg", report_reg, v[0]);
      check("warning_reg", warning_reg, v[1]);
      check("error_reg", error_reg, v[2]);
      check("measured_reg", measured_reg, v[4]);
      wr(A_WARNING, 32'hA5A5_A5A5, 4'b1010);
      rd("rd_warning_be", A_WARNING, {8'hA5, v[1][23:16], 8'hA5, v[1][7:0]});
    end
    wr(A_EXPECTED, 32'hDEAD_BEEF, 4'b0011);
    rd("rd_expected_be", A_EXPECTED, 32'h0000_BEEF);
    check("expected_reg", expected_reg, 32'h0000_BEEF);

    // String "PASS" + terminator
    str_wr(8'h50, 0, 1'b1);
    str_wr(8'h41, 1, 1'b1);
    str_wr(8'h53, 2, 1'b1);
    str_wr(8'h53, 3, 1'b1);
    str_wr(8'h00, 4, 1'b1);
    rd("status_after_pass", A_STATUS, 32'd0);
    // Byte lane 0 disabled: nothing written, pointer untouched
    wr(A_STRING, 32'h0000_0041, 4'b1110);
    rd("status_sel0_off", A_STATUS, 32'd0);

    // 64 nonzero bytes: 63 written, 64th overflows
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(1, 255));
      str_wr(b, i, (i < 63));
    end
    rd("status_overflow", A_STATUS, {23'b0, 6'd63, 1'b1, 1'b0, 1'b0});
    wr(A_STATUS, 32'h4, 4'hF);
    rd("status_ovf_clr", A_STATUS, {23'b0, 6'd63, 3'b000});
    str_wr(8'h00, 63, 1'b1);
    rd("status_ptr_rst", A_STATUS, 32'd0);

    // Pulse CTRL=0x9 with a dropped CTRL=0x2 during PULSE
    wr(A_CTRL, 32'h9, 4'hF);
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          @(negedge wb_clk_i);
          strb_log[i] = strobes;
          busy_log[i] = dut.busy;
        end
      end
      wr(A_CTRL, 32'h2, 4'hF);
    join
    for (int i = 0; i < 4; i++) check($sformatf("pulse_hi_%0d", i), {28'b0, strb_log[i]}, 32'h9);
    check("pulse_busy0", {31'b0, busy_log[0]}, 32'd1);
    check("pulse_gap", {28'b0, strb_log[4]}, 32'h0);
    check("pulse_gap_busy", {31'b0, busy_log[4]}, 32'd1);
    check("pulse_idle_busy", {31'b0, busy_log[5]}, 32'd0);
    check("pulse_idle_strb", {28'b0, strb_log[5]}, 32'h0);
    rd("status_dropped", A_STATUS, 32'h2);
    wr(A_STATUS, 32'h2, 4'hF);
    rd("status_drop_clr", A_STATUS, 32'd0);

    // Reset on the 2nd strobe cycle, with a bus cycle pending
    wr(A_CTRL, 32'h1, 4'hF);
    @(negedge wb_clk_i);
    check("rstp_hi1", {28'b0, strobes}, 32'h1);
    @(negedge wb_clk_i);
    check("rstp_hi2", {28'b0, strobes}, 32'h1);
    wb_rst_i = 1'b0;
    wb_adr_i = A_REPORT; wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("rstp_strb_drop", {28'b0, strobes}, 32'h0);
    check("rstp_no_ack", {31'b0, wb_ack_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk_i);
    check("rstp_report", report_reg, 32'd0);
    check("rstp_expected", expected_reg, 32'd0);
    wb_rst_i = 1'b1;
    rd("rstp_status", A_STATUS, 32'd0);
    wr(A_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      strb_log[i] = strobes;
      busy_log[i] = dut.busy;
    end
    for (int i = 0; i < 4; i++) check($sformatf("rpulse_hi_%0d", i), {28'b0, strb_log[i]}, 32'h1);
    check("rpulse_gap", {28'b0, strb_log[4]}, 32'h0);
    check("rpulse_idle", {31'b0, busy_log[5]}, 32'd0);

    repeat (3) @(negedge wb_clk_i);
    check("str_queue_empty", 32'(str_exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
